// File: rtl/pre_tx_unit_pkg.sv
// Shared types and defaults for the TX FIFO write-request generator.
package pre_tx_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } tx_state_e;

    localparam int BURST_LEN_DEF = 200;
    localparam int WR_DIV_DEF    = 1;

endpackage

// File: rtl/pre_tx_unit_sync_2ff.sv
// Generic two-flop level synchronizer; both flops clear on async reset.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pre_tx_unit.sv
// Paced burst of FIFO write strobes per Data_Available window; re-arms only
// after the level drops. All outputs are registered.
module pre_tx_unit
    import pre_tx_unit_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int WR_DIV    = WR_DIV_DEF,
    parameter int CNT_W     = 16
) (
    input  logic             Mclk,
    input  logic             Reset,
    input  logic             Data_Available,
    output logic             fifo_wrreq,
    output logic [CNT_W-1:0] wr_count,
    output logic             busy
);

    localparam int               PACE_W      = 8;
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(WR_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  CNT_PENULT  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

    logic da_s;

    tx_state_e         state, state_nxt;
    logic [PACE_W-1:0] pace_cnt, pace_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              wrreq_nxt;
    logic              strobe_due;
    logic              last_due;

    sync_2ff #(.W(1)) u_da_sync (
        .clk (Mclk),
        .rst (Reset),
        .d   (Data_Available),
        .q   (da_s)
    );

    assign strobe_due = (pace_cnt == '0);
    // The final strobe of a burst is allowed through even if the source drops
    // on that same edge.
    assign last_due   = strobe_due && (wr_count == CNT_PENULT);

    always_comb begin
        state_nxt = state;
        wrreq_nxt = 1'b0;
        cnt_nxt   = wr_count;
        pace_nxt  = pace_cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (da_s) begin
                    state_nxt = WRITE;
                    wrreq_nxt = 1'b1;
                    cnt_nxt   = CNT_ONE;
                    pace_nxt  = PACE_RELOAD;
                end
            end
            WRITE: begin
                // The last strobe is on the wire this cycle; retire to DONE.
                if (wr_count == CNT_LAST) begin
                    state_nxt = DONE;
                end else if (!da_s && !last_due) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (strobe_due) begin
                    wrreq_nxt = 1'b1;
                    cnt_nxt   = wr_count + CNT_ONE;
                    pace_nxt  = PACE_RELOAD;
                end else begin
                    pace_nxt  = pace_cnt - PACE_W'(1);
                end
            end
            DONE: begin
                if (!da_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Mclk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            pace_cnt   <= '0;
            fifo_wrreq <= 1'b0;
            wr_count   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pace_cnt   <= pace_nxt;
            fifo_wrreq <= wrreq_nxt;
            wr_count   <= cnt_nxt;
            busy       <= (state_nxt == WRITE);
        end
    end

endmodule

// File: tb/tb_pre_tx_unit.sv
// Bench for pre_tx_unit: two parameterizations driven from one source level,
// checked every cycle against a burst-window model plus scenario tables.
module tb_pre_tx_unit;

    localparam int BL0 = 200, WD0 = 1;
    localparam int BL1 = 10,  WD1 = 4;

    logic        Mclk = 1'b0;
    logic        Reset = 1'b1;
    logic        Data_Available = 1'b0;
    logic        wr0, busy0, wr1, busy1;
    logic [15:0] cnt0, cnt1;

    pre_tx_unit #(.BURST_LEN(BL0), .WR_DIV(WD0), .CNT_W(16)) dut0 (
        .Mclk(Mclk), .Reset(Reset), .Data_Available(Data_Available),
        .fifo_wrreq(wr0), .wr_count(cnt0), .busy(busy0)
    );

    pre_tx_unit #(.BURST_LEN(BL1), .WR_DIV(WD1), .CNT_W(16)) dut1 (
        .Mclk(Mclk), .Reset(Reset), .Data_Available(Data_Available),
        .fifo_wrreq(wr1), .wr_count(cnt1), .busy(busy1)
    );

    always #5 Mclk = ~Mclk;

    int vectors = 0;
    int miscompares = 0;

    // Model: source level seen two edges late; a burst is a window anchored
    // at its start edge, strobes at start + k*WR_DIV.
    int ecnt = 0;
    bit h1 = 1'b0, h2 = 1'b0;
    int m_mode [2];   // 0 idle, 1 bursting, 2 burst complete
    int m_n    [2];
    int m_start[2];
    bit m_wr   [2];

    int sc0, sc1, tk, first0, last0, first1, last1;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        h1 = 1'b0;
        h2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_n[i] = 0; m_wr[i] = 1'b0; m_start[i] = 0;
        end
    endtask

    task automatic model_edge(input bit ds);
        int bl, wd;
        bit due;
        for (int i = 0; i < 2; i++) begin
            bl = (i == 0) ? BL0 : BL1;
            wd = (i == 0) ? WD0 : WD1;
            m_wr[i] = 1'b0;
            if (m_mode[i] == 0) begin
                m_n[i] = 0;
                if (ds) begin
                    m_mode[i] = 1; m_start[i] = ecnt; m_n[i] = 1; m_wr[i] = 1'b1;
                end
            end else if (m_mode[i] == 1) begin
                if (m_n[i] == bl) begin
                    m_mode[i] = 2;
                end else begin
                    due = ((ecnt - m_start[i]) % wd) == 0;
                    if (!ds && !(due && m_n[i] == bl - 1)) begin
                        m_mode[i] = 0; m_n[i] = 0;
                    end else if (due) begin
                        m_wr[i] = 1'b1; m_n[i]++;
                    end
                end
            end else begin
                if (!ds) begin
                    m_mode[i] = 0; m_n[i] = 0;
                end
            end
        end
    endtask

    task automatic clr();
        sc0 = 0; sc1 = 0; tk = 0;
        first0 = -1; last0 = -1; first1 = -1; last1 = -1;
    endtask

    // Drive one cycle (called just after a falling edge), then compare.
    task automatic tick(input bit da);
        Data_Available = da;
        @(posedge Mclk);
        model_edge(h2);
        h2 = h1;
        h1 = da;
        ecnt++;
        #1;
        tk++;
        check_eq("wrreq0", 32'(wr0),   32'(m_wr[0]));
        check_eq("count0", 32'(cnt0),  32'(m_n[0]));
        check_eq("busy0",  32'(busy0), 32'(m_mode[0] == 1));
        check_eq("wrreq1", 32'(wr1),   32'(m_wr[1]));
        check_eq("count1", 32'(cnt1),  32'(m_n[1]));
        check_eq("busy1",  32'(busy1), 32'(m_mode[1] == 1));
        if (wr0 === 1'b1) begin
            sc0++; if (first0 < 0) first0 = tk; last0 = tk;
        end
        if (wr1 === 1'b1) begin
            sc1++; if (first1 < 0) first1 = tk; last1 = tk;
        end
        @(negedge Mclk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wrreq0"}, 32'(wr0),   32'd0);
        check_eq({tag, "_count0"}, 32'(cnt0),  32'd0);
        check_eq({tag, "_busy0"},  32'(busy0), 32'd0);
        check_eq({tag, "_wrreq1"}, 32'(wr1),   32'd0);
        check_eq({tag, "_count1"}, 32'(cnt1),  32'd0);
        check_eq({tag, "_busy1"},  32'(busy1), 32'd0);
    endtask

    typedef struct {
        int lo;
        int hi;
        int exp0;
        int exp1;
    } row_t;

    row_t rows [10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit val;
        int len;

        // Window lengths seen by the synchronizer -> strobe counts per burst.
        rows[0] = '{50, 256, 200, 10};
        rows[1] = '{50, 256, 200, 10};
        rows[2] = '{50, 256, 200, 10};
        rows[3] = '{50, 256, 200, 10};
        rows[4] = '{20,  37,  37, 10};
        rows[5] = '{20,  36,  36, 10};   // last slow strobe lands on the drop edge
        rows[6] = '{20,  35,  35,  9};
        rows[7] = '{ 5,   1,   1,  1};
        rows[8] = '{30, 199, 200, 10};   // final strobe coincides with abort
        rows[9] = '{30, 198, 198, 10};

        model_reset();
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge Mclk);

        // Source already high at reset release.
        Data_Available = 1'b1;
        Reset = 1'b0;
        clr();
        repeat (256) tick(1'b1);
        check_eq("first_strobe_edge0", 32'(first0), 32'd3);
        check_eq("burst_len0",         32'(sc0), 32'd200);
        check_eq("burst_contig0",      32'(last0 - first0 + 1), 32'd200);
        check_eq("final_count0",       32'(cnt0), 32'd200);
        check_eq("busy_fell0",         32'(busy0), 32'd0);
        check_eq("first_strobe_edge1", 32'(first1), 32'd3);
        check_eq("burst_len1",         32'(sc1), 32'd10);
        check_eq("first_to_last1",     32'(last1 - first1), 32'd36);
        clr();
        repeat (744) tick(1'b1);
        check_eq("no_retrigger0", 32'(sc0), 32'd0);
        check_eq("no_retrigger1", 32'(sc1), 32'd0);
        check_eq("held_count0",   32'(cnt0), 32'd200);

        foreach (rows[r]) begin
            repeat (rows[r].lo) tick(1'b0);
            clr();
            repeat (rows[r].hi) tick(1'b1);
            repeat (6) tick(1'b0);
            check_eq($sformatf("row%0d_strobes0", r), 32'(sc0), 32'(rows[r].exp0));
            check_eq($sformatf("row%0d_strobes1", r), 32'(sc1), 32'(rows[r].exp1));
            check_eq($sformatf("row%0d_cleared0", r), 32'(cnt0), 32'd0);
            check_eq($sformatf("row%0d_cleared1", r), 32'(cnt1), 32'd0);
        end

        // Abort after 50 strobes, then a fresh full burst.
        repeat (10) tick(1'b0);
        for (int i = 0; i < 300 && cnt0 != 16'd50; i++) tick(1'b1);
        check_eq("reach_50", 32'(cnt0), 32'd50);
        clr();
        repeat (6) tick(1'b0);
        check_eq("abort_extra_strobes", 32'(sc0), 32'd2);
        check_eq("abort_count",         32'(cnt0), 32'd0);
        check_eq("abort_busy",          32'(busy0), 32'd0);
        clr();
        repeat (256) tick(1'b1);
        repeat (6) tick(1'b0);
        check_eq("rearm_burst0", 32'(sc0), 32'd200);

        // Reset in the middle of a burst.
        repeat (10) tick(1'b0);
        for (int i = 0; i < 300 && cnt0 != 16'd120; i++) tick(1'b1);
        check_eq("reach_120", 32'(cnt0), 32'd120);
        Data_Available = 1'b1;
        Reset = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        repeat (2) @(negedge Mclk);
        Reset = 1'b0;
        clr();
        repeat (260) tick(1'b1);
        check_eq("post_reset_burst0", 32'(sc0), 32'd200);
        check_eq("post_reset_count0", 32'(cnt0), 32'd200);
        check_eq("post_reset_burst1", 32'(sc1), 32'd10);

        // Random source windows, every cycle checked against the model.
        val = 1'b1;
        repeat (16) begin
            val = ~val;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 250);
            repeat (len) tick(val);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pre_tx_unit.md
Name: pre_tx_unit

Overview:
- Write-request generator in front of the transmit FIFO.
- While the upstream source flags Data_Available, it issues a paced burst of single-cycle fifo_wrreq strobes, up to a fixed burst length.
- It then waits for Data_Available to drop before re-arming.
- It sits between the sample source and the TX FIFO write port, in the Mclk domain.

Parameters:
- BURST_LEN, 200, number of write strobes per Data_Available window (1..65535).
- WR_DIV, 1, Mclk cycles between consecutive strobes (1 = every cycle; 1..255).
- CNT_W, 16, width of wr_count; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- Mclk  input  1  system clock, rising edge; all state in this domain.
- Reset  input  1  asynchronous, active-high reset.
- Data_Available  input  1  level from source, asynchronous to Mclk; high = samples ready.
- fifo_wrreq  output  1  registered FIFO write strobe, one Mclk cycle per write.
- wr_count  output  CNT_W  writes issued in the current burst.
- busy  output  1  high while in WRITE state.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - fifo_wrreq=0, wr_count=0, busy=0, state=IDLE.
  - Synchronizer flops = 0; pacing counter = 0.
- Input synchronizer:
  - Data_Available passes through a 2-flop synchronizer; da_s is the second flop.
  - All decisions use da_s only.
- States: IDLE, WRITE, DONE.
- IDLE:
  - fifo_wrreq=0, wr_count held at 0.
  - If da_s=1, go to WRITE on the next edge. This is level-sensitive, so Data_Available already high at reset release starts a burst.
- WRITE:
  - On entry, fifo_wrreq=1 in the first WRITE cycle; the pacing counter is loaded with WR_DIV-1.
  - Each subsequent strobe occurs when the pacing counter reaches 0, then the counter reloads WR_DIV-1; otherwise the counter decrements.
  - fifo_wrreq is never high for two consecutive cycles unless WR_DIV=1.
  - wr_count increments in the same cycle each strobe is asserted, so it equals the number of strobes issued including the current one.
  - When the strobe that makes wr_count=BURST_LEN is issued, the next state is DONE.
  - If da_s=0 while in WRITE, the next state is IDLE (abort): no further strobes, wr_count cleared on entry to IDLE, partial burst not resumed.
  - Simultaneous abort and final strobe in the same cycle: the final strobe still issues; DONE wins for that edge, then DONE sees da_s=0 and returns to IDLE.
- DONE:
  - fifo_wrreq=0, wr_count holds BURST_LEN.
  - If da_s=0, go to IDLE (wr_count cleared).
  - A Data_Available that stays high never triggers a second burst.
- busy = (state==WRITE), registered.
- Latency: Data_Available rises with setup before edge k → da_s high after edge k+1 → first fifo_wrreq high after edge k+2 (3 edges total).
- Falling-edge abort latency: Data_Available low before edge k → no strobe from edge k+2 onward.
- Glitches shorter than one Mclk period may be missed; no filtering required.
- Reset asserted mid-burst: immediate return to IDLE with all outputs 0. A burst restarts only after reset release, with da_s re-synchronized.

Decomposition:
- Shared package: state enum (IDLE, WRITE, DONE) and default constants BURST_LEN_DEF=200, WR_DIV_DEF=1.
- One natural sub-module: sync_2ff (generic 2-flop level synchronizer, async active-high reset to 0), instantiated for Data_Available.
- Pacing counter and FSM stay in the top module.

Test Plan:
- Reset, then hold Data_Available=1 for 256 cycles (WR_DIV=1) → first strobe 3 edges after reset release, exactly 200 consecutive strobes, wr_count=200, busy falls, fifo_wrreq stays 0 for the remainder.
- Data_Available low for 50 cycles, then high for 256 cycles, repeated four times → 4 bursts of 200 strobes each; wr_count returns to 0 between bursts.
- WR_DIV=4, BURST_LEN=10, Data_Available high → strobes exactly every 4th cycle, 10 total; last strobe 36 cycles after the first.
- Drop Data_Available after 50 strobes → strobes stop within 2 cycles (≤2 extra), state IDLE, wr_count=0. Re-raise → fresh burst of 200.
- Assert Reset mid-burst (wr_count=120) → fifo_wrreq, busy and wr_count go to 0 asynchronously. After release with Data_Available high → new full 200-strobe burst.
- Data_Available stays high for 1000 cycles → exactly one burst of 200; no re-trigger until it goes low and high again.
